// File: rtl/memory_address_pkg.sv
// Shared types for the memory address sequencer: FSM states, default widths and
// the single place where the priority between the command inputs is decided.
package memory_address_pkg;

    localparam int DEFAULT_ADDR_W = 4;
    localparam int DEFAULT_LEN_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE    = 2'd0,
        CMD_LOAD    = 2'd1,
        CMD_BURST   = 2'd2,
        CMD_ADVANCE = 2'd3
    } cmd_e;

    // Load beats everything; burst_start and increment only count in IDLE,
    // step only counts in BURST, so one advance command serves both states.
    function automatic cmd_e decode_cmd(
        input state_e state,
        input logic   load_enable,
        input logic   burst_start,
        input logic   increment,
        input logic   step
    );
        cmd_e cmd;
        cmd = CMD_NONE;
        if (load_enable) begin
            cmd = CMD_LOAD;
        end else if (state == IDLE) begin
            if (burst_start) begin
                cmd = CMD_BURST;
            end else if (increment) begin
                cmd = CMD_ADVANCE;
            end
        end else if (step) begin
            cmd = CMD_ADVANCE;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/burst_length_counter.sv
// Down-counter holding the number of words left in the current burst;
// flags the last word so the sequencer can finish on the consuming step.
module burst_length_counter #(
    parameter int LEN_W = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_load_value,
    input  logic             i_decrement,
    output logic             o_last
);

    logic [LEN_W-1:0] remaining_reg;
    logic [LEN_W-1:0] remaining_next;

    always_comb begin
        remaining_next = remaining_reg;
        if (i_clear) begin
            remaining_next = '0;
        end else if (i_load) begin
            remaining_next = i_load_value;
        end else if (i_decrement && (remaining_reg != '0)) begin
            remaining_next = remaining_reg - LEN_W'(1);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            remaining_reg <= '0;
        end else begin
            remaining_reg <= remaining_next;
        end
    end

    assign o_last = (remaining_reg == LEN_W'(1));

endmodule

// File: rtl/memory_address_sequencer.sv
// Address register with bus load, single-step increment and step-handshaked bursts.
// Define MAR_BOUND_EN to add the o_fault port and the ADDR_LIMIT range check.
module memory_address_sequencer
    import memory_address_pkg::*;
#(
    parameter int          ADDR_W     = DEFAULT_ADDR_W,
    parameter int          LEN_W      = DEFAULT_LEN_W,
    parameter int unsigned RESET_ADDR = 0,
    parameter int unsigned ADDR_LIMIT = 2**ADDR_W - 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_load_enable,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_increment,
    input  logic              i_burst_start,
    input  logic [LEN_W-1:0]  i_burst_len,
    input  logic              i_step,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_burst_active,
    output logic              o_burst_done
`ifdef MAR_BOUND_EN
    ,
    output logic              o_fault
`endif
);

    if (longint'(ADDR_LIMIT) > ((longint'(1) << ADDR_W) - 1)) begin : g_bad_limit
        $error("ADDR_LIMIT does not fit in ADDR_W bits");
    end

    state_e            state_reg;
    state_e            state_next;
    cmd_e              cmd;
    logic [ADDR_W-1:0] address_reg;
    logic [ADDR_W-1:0] address_next;
    logic              done_reg;
    logic              done_next;
    logic              cnt_clear;
    logic              cnt_load;
    logic              cnt_decrement;
    logic              last_word;
    logic              burst_len_zero;
    logic              advance_fault;

    assign cmd            = decode_cmd(state_reg, i_load_enable, i_burst_start, i_increment, i_step);
    assign burst_len_zero = (i_burst_len == '0);

`ifdef MAR_BOUND_EN
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(ADDR_LIMIT);

    logic fault_reg;
    logic fault_next;
    logic load_fault;

    // An advance from LIMIT or above either exceeds the limit or wraps.
    assign advance_fault = (cmd == CMD_ADVANCE) && (address_reg >= LIMIT);
    assign load_fault    = (cmd == CMD_LOAD) && (i_address > LIMIT);
    assign fault_next    = fault_reg | advance_fault | load_fault;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            fault_reg <= 1'b0;
        end else begin
            fault_reg <= fault_next;
        end
    end

    assign o_fault = fault_reg;
`else
    assign advance_fault = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if ((cmd == CMD_BURST) && !burst_len_zero) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                if (cmd == CMD_LOAD) begin
                    state_next = IDLE;
                end else if ((cmd == CMD_ADVANCE) && (last_word || advance_fault)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values for the registered address and done pulse,
    // plus the commands to the burst length counter.
    always_comb begin
        address_next  = address_reg;
        done_next     = 1'b0;
        cnt_clear     = 1'b0;
        cnt_load      = 1'b0;
        cnt_decrement = 1'b0;
        case (cmd)
            CMD_LOAD: begin
                address_next = i_address;
                cnt_clear    = (state_reg == BURST);
            end
            CMD_BURST: begin
                if (burst_len_zero) begin
                    done_next = 1'b1;
                end else begin
                    cnt_load = 1'b1;
                end
            end
            CMD_ADVANCE: begin
                if (advance_fault) begin
                    // Out-of-range advance wraps and silently ends any burst.
                    address_next = '0;
                    cnt_clear    = (state_reg == BURST);
                end else begin
                    address_next = address_reg + ADDR_W'(1);
                    if (state_reg == BURST) begin
                        cnt_decrement = 1'b1;
                        done_next     = last_word;
                    end
                end
            end
            default: begin
                address_next = address_reg;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            address_reg <= ADDR_W'(RESET_ADDR);
            done_reg    <= 1'b0;
        end else begin
            address_reg <= address_next;
            done_reg    <= done_next;
        end
    end

    burst_length_counter #(
        .LEN_W(LEN_W)
    ) u_burst_length_counter (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (cnt_clear),
        .i_load       (cnt_load),
        .i_load_value (i_burst_len),
        .i_decrement  (cnt_decrement),
        .o_last       (last_word)
    );

    assign o_address      = address_reg;
    assign o_burst_active = (state_reg == BURST);
    assign o_burst_done   = done_reg;

endmodule

// File: tb/tb_memory_address_sequencer.sv
// Self-checking bench for memory_address_sequencer: directed vector table,
// hand-written corner sequences and random traffic against a reference model.
module tb_memory_address_sequencer;

    localparam int LIMIT = 11;
`ifdef MAR_BOUND_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    logic       i_clock = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_load_enable = 1'b0;
    logic [3:0] i_address = '0;
    logic       i_increment = 1'b0;
    logic       i_burst_start = 1'b0;
    logic [3:0] i_burst_len = '0;
    logic       i_step = 1'b0;
    logic [3:0] o_address;
    logic       o_burst_active;
    logic       o_burst_done;
`ifdef MAR_BOUND_EN
    logic       o_fault;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 i_clock = ~i_clock;

    memory_address_sequencer #(
        .ADDR_W     (4),
        .LEN_W      (4),
        .RESET_ADDR (0),
        .ADDR_LIMIT (LIMIT)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_load_enable  (i_load_enable),
        .i_address      (i_address),
        .i_increment    (i_increment),
        .i_burst_start  (i_burst_start),
        .i_burst_len    (i_burst_len),
        .i_step         (i_step),
        .o_address      (o_address),
        .o_burst_active (o_burst_active),
        .o_burst_done   (o_burst_done)
`ifdef MAR_BOUND_EN
        ,
        .o_fault        (o_fault)
`endif
    );

    // Reference model: address as an integer, words left in the burst as a count.
    int m_addr;
    int m_left;
    bit m_busy;
    bit m_done;
    bit m_fault;

    function automatic void m_reset();
        m_addr  = 0;
        m_left  = 0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_fault = 1'b0;
    endfunction

    function automatic bit m_advance();
        if (BOUND && (m_addr >= LIMIT)) begin
            m_fault = 1'b1;
            m_addr  = 0;
            return 1'b0;
        end
        m_addr = (m_addr + 1) % 16;
        return 1'b1;
    endfunction

    function automatic void m_edge(bit ld, int a, bit bs, int len, bit inc, bit st);
        m_done = 1'b0;
        if (ld) begin
            m_addr = a;
            m_busy = 1'b0;
            if (BOUND && (a > LIMIT)) m_fault = 1'b1;
        end else if (!m_busy) begin
            if (bs) begin
                if (len == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_busy = 1'b1;
                    m_left = len;
                end
            end else if (inc) begin
                void'(m_advance());
            end
        end else if (st) begin
            if (!m_advance()) begin
                m_busy = 1'b0;
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_addr"}, 8'(o_address), 8'(m_addr));
        check({tag, "_active"}, 8'(o_burst_active), 8'(m_busy));
        check({tag, "_done"}, 8'(o_burst_done), 8'(m_done));
`ifdef MAR_BOUND_EN
        check({tag, "_fault"}, 8'(o_fault), 8'(m_fault));
`endif
    endtask

    task automatic apply(input bit ld, input logic [3:0] a, input bit bs,
                         input logic [3:0] len, input bit inc, input bit st);
        i_load_enable = ld;
        i_address     = a;
        i_burst_start = bs;
        i_burst_len   = len;
        i_increment   = inc;
        i_step        = st;
        m_edge(ld, int'(a), bs, int'(len), inc, st);
        @(posedge i_clock);
        #1;
        i_load_enable = 1'b0;
        i_burst_start = 1'b0;
        i_increment   = 1'b0;
        i_step        = 1'b0;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        m_reset();
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
    endtask

    typedef struct {
        string      name;
        bit         ld;
        logic [3:0] a;
        bit         bs;
        logic [3:0] len;
        bit         inc;
        bit         st;
        logic [3:0] e_addr;
        bit         e_act;
        bit         e_done;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        check_model("reset");
        check("reset_addr_const", 8'(o_address), 8'h00);

`ifndef MAR_BOUND_EN
        //               name        ld a     bs len   inc st  addr  act done
        vecs.push_back('{"t1_load",   1, 4'hA, 0, 4'd0, 0, 0, 4'hA, 0, 0});
        vecs.push_back('{"t1_inc1",   0, 4'h0, 0, 4'd0, 1, 0, 4'hB, 0, 0});
        vecs.push_back('{"t1_inc2",   0, 4'h0, 0, 4'd0, 1, 0, 4'hC, 0, 0});
        vecs.push_back('{"t1_inc3",   0, 4'h0, 0, 4'd0, 1, 0, 4'hD, 0, 0});
        vecs.push_back('{"t2_load",   1, 4'hE, 0, 4'd0, 0, 0, 4'hE, 0, 0});
        vecs.push_back('{"t2_start",  0, 4'h0, 1, 4'd3, 0, 0, 4'hE, 1, 0});
        vecs.push_back('{"t2_hold1",  0, 4'h0, 0, 4'd0, 0, 0, 4'hE, 1, 0});
        vecs.push_back('{"t2_step1",  0, 4'h0, 0, 4'd0, 0, 1, 4'hF, 1, 0});
        vecs.push_back('{"t2_hold2",  0, 4'h0, 0, 4'd0, 0, 0, 4'hF, 1, 0});
        vecs.push_back('{"t2_step2",  0, 4'h0, 0, 4'd0, 0, 1, 4'h0, 1, 0});
        vecs.push_back('{"t2_hold3",  0, 4'h0, 0, 4'd0, 0, 0, 4'h0, 1, 0});
        vecs.push_back('{"t2_step3",  0, 4'h0, 0, 4'd0, 0, 1, 4'h1, 0, 1});
        vecs.push_back('{"t2_after",  0, 4'h0, 0, 4'd0, 0, 0, 4'h1, 0, 0});
        vecs.push_back('{"t3_len0",   0, 4'h0, 1, 4'd0, 0, 0, 4'h1, 0, 1});
        vecs.push_back('{"t3_after",  0, 4'h0, 0, 4'd0, 0, 0, 4'h1, 0, 0});
        vecs.push_back('{"t4_start",  0, 4'h0, 1, 4'd4, 0, 0, 4'h1, 1, 0});
        vecs.push_back('{"t4_step1",  0, 4'h0, 0, 4'd0, 0, 1, 4'h2, 1, 0});
        vecs.push_back('{"t4_step2",  0, 4'h0, 0, 4'd0, 0, 1, 4'h3, 1, 0});
        vecs.push_back('{"t4_abort",  1, 4'h5, 0, 4'd0, 0, 1, 4'h5, 0, 0});
        vecs.push_back('{"t4_stepig", 0, 4'h0, 0, 4'd0, 0, 1, 4'h5, 0, 0});
        vecs.push_back('{"bb_start",  0, 4'h0, 1, 4'd1, 0, 0, 4'h5, 1, 0});
        vecs.push_back('{"bb_lastbs", 0, 4'h0, 1, 4'd2, 0, 1, 4'h6, 0, 1});
        vecs.push_back('{"bb_ondone", 0, 4'h0, 1, 4'd1, 0, 0, 4'h6, 1, 0});
        vecs.push_back('{"bb_step",   0, 4'h0, 0, 4'd0, 0, 1, 4'h7, 0, 1});
        vecs.push_back('{"idle_inc",  0, 4'h0, 0, 4'd0, 1, 1, 4'h8, 0, 0});
        vecs.push_back('{"bs_vs_inc", 0, 4'h0, 1, 4'd2, 1, 0, 4'h8, 1, 0});
        vecs.push_back('{"b_inc_ig",  0, 4'h0, 0, 4'd0, 1, 0, 4'h8, 1, 0});
        vecs.push_back('{"b_bs_ig",   0, 4'h0, 1, 4'd5, 0, 0, 4'h8, 1, 0});
        vecs.push_back('{"b_step1",   0, 4'h0, 0, 4'd0, 0, 1, 4'h9, 1, 0});
        vecs.push_back('{"b_step2",   0, 4'h0, 0, 4'd0, 0, 1, 4'hA, 0, 1});

        foreach (vecs[k]) begin
            apply(vecs[k].ld, vecs[k].a, vecs[k].bs, vecs[k].len, vecs[k].inc, vecs[k].st);
            $display("vec %s addr=%0h active=%0b done=%0b", vecs[k].name,
                     o_address, o_burst_active, o_burst_done);
            check({vecs[k].name, "_addr"}, 8'(o_address), 8'(vecs[k].e_addr));
            check({vecs[k].name, "_active"}, 8'(o_burst_active), 8'(vecs[k].e_act));
            check({vecs[k].name, "_done"}, 8'(o_burst_done), 8'(vecs[k].e_done));
        end
`endif

        // Asynchronous reset between edges in the middle of a burst
        do_reset();
        apply(1, 4'h3, 0, 4'd0, 0, 0);
        apply(0, 4'h0, 1, 4'd4, 0, 0);
        apply(0, 4'h0, 0, 4'd0, 0, 1);
        $display("async pre-reset addr=%0h active=%0b", o_address, o_burst_active);
        check("async_pre_active", 8'(o_burst_active), 8'h01);
        #2;
        i_reset = 1'b1;
        #1;
        $display("async in-reset addr=%0h active=%0b done=%0b", o_address, o_burst_active, o_burst_done);
        check("async_addr", 8'(o_address), 8'h00);
        check("async_active", 8'(o_burst_active), 8'h00);
        check("async_done", 8'(o_burst_done), 8'h00);
        m_reset();
        #1;
        i_reset = 1'b0;
        apply(0, 4'h0, 0, 4'd0, 1, 0);
        $display("async post-reset inc addr=%0h", o_address);
        check("async_inc_addr", 8'(o_address), 8'h01);
        check_model("async_inc");

`ifdef MAR_BOUND_EN
        do_reset();
        apply(1, 4'hB, 0, 4'd0, 0, 0);
        check("bnd_load_limit_nofault", 8'(o_fault), 8'h00);
        apply(0, 4'h0, 0, 4'd0, 1, 0);
        $display("bound inc past limit addr=%0h fault=%0b", o_address, o_fault);
        check("bnd_inc_fault", 8'(o_fault), 8'h01);
        check("bnd_inc_wrap", 8'(o_address), 8'h00);
        apply(1, 4'h2, 0, 4'd0, 0, 0);
        check("bnd_sticky", 8'(o_fault), 8'h01);
        do_reset();
        check("bnd_reset_clear", 8'(o_fault), 8'h00);
        apply(1, 4'hC, 0, 4'd0, 0, 0);
        $display("bound load over limit addr=%0h fault=%0b", o_address, o_fault);
        check("bnd_load_over", 8'(o_fault), 8'h01);
        do_reset();
        apply(1, 4'h9, 0, 4'd0, 0, 0);
        apply(0, 4'h0, 1, 4'd5, 0, 0);
        apply(0, 4'h0, 0, 4'd0, 0, 1);
        apply(0, 4'h0, 0, 4'd0, 0, 1);
        check("bnd_burst_at_limit", 8'(o_address), 8'h0B);
        apply(0, 4'h0, 0, 4'd0, 0, 1);
        $display("bound burst cross addr=%0h active=%0b done=%0b fault=%0b",
                 o_address, o_burst_active, o_burst_done, o_fault);
        check("bnd_burst_addr", 8'(o_address), 8'h00);
        check("bnd_burst_active", 8'(o_burst_active), 8'h00);
        check("bnd_burst_done", 8'(o_burst_done), 8'h00);
        check("bnd_burst_fault", 8'(o_fault), 8'h01);
        apply(0, 4'h0, 0, 4'd0, 0, 0);
        check("bnd_burst_nodone", 8'(o_burst_done), 8'h00);
`endif

        // Random traffic against the reference model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bit         ld;
            bit         bs;
            bit         inc;
            bit         st;
            logic [3:0] a;
            logic [3:0] len;
            if ((i % 100) == 50) do_reset();
            ld  = ($urandom_range(0, 9) == 0);
            a   = 4'($urandom_range(0, 15));
            bs  = ($urandom_range(0, 3) == 0);
            len = 4'($urandom_range(0, 5));
            inc = ($urandom_range(0, 2) == 0);
            st  = 1'($urandom_range(0, 1));
            apply(ld, a, bs, len, inc, st);
            $display("rnd %0d ld=%0b a=%0h bs=%0b len=%0d inc=%0b st=%0b -> addr=%0h active=%0b done=%0b",
                     i, ld, a, bs, len, inc, st, o_address, o_burst_active, o_burst_done);
            check_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
